// File: rtl/speed_ctrl_pkg.sv
// Shared types, widths and the saturating helper for the speed PI controller.
package speed_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WAIT = 3'd1,
      ERR  = 3'd2,
      MUL  = 3'd3,
      ACC  = 3'd4,
      OUT  = 3'd5
   } state_t;

   localparam int ERR_W   = 17;  // setpoint - sample, both 16-bit unsigned
   localparam int PROD_W  = 26;  // 8-bit gain times 17-bit error
   localparam int SUM_W   = 27;  // product plus integrator
   localparam int CLAMP_W = 32;  // common width for all saturating compares

   // Saturate a signed value into [lo, hi].
   function automatic logic signed [CLAMP_W-1:0] clamp_s(
      input logic signed [CLAMP_W-1:0] value,
      input logic signed [CLAMP_W-1:0] lo,
      input logic signed [CLAMP_W-1:0] hi
   );
      if (value < lo) begin
         return lo;
      end
      if (value > hi) begin
         return hi;
      end
      return value;
   endfunction

endpackage

// File: rtl/speed_pi_controller_if.sv
// Register-side and tachometer/PWM-side signals of the speed PI controller.
interface speed_pi_controller_if;

   logic        enable;
   logic        sample_valid;
   logic [31:0] sample_count;
   logic [15:0] setpoint;
   logic [7:0]  kp;
   logic [7:0]  ki;
   logic [7:0]  duty;
   logic        duty_valid;
   logic        busy;
   logic        saturated;
   logic        overrun;

   // The environment (processor registers and tachometer) drives the controller.
   modport master (
      output enable, sample_valid, sample_count, setpoint, kp, ki,
      input  duty, duty_valid, busy, saturated, overrun
   );

   // The controller consumes samples and produces the duty command.
   modport slave (
      input  enable, sample_valid, sample_count, setpoint, kp, ki,
      output duty, duty_valid, busy, saturated, overrun
   );

endinterface

// File: rtl/pi_datapath.sv
// Error, product, integrator and duty registers of the PI loop; each stage
// advances only when the controlling FSM raises its enable.
module pi_datapath
   import speed_ctrl_pkg::*;
#(
   parameter int FRAC_BITS = 4,
   parameter int INT_WIDTH = 24,
   parameter int INT_LIMIT = 1048575,
   parameter int DUTY_MAX  = 255
) (
   input  logic        clock,
   input  logic        system_reset,
   input  logic        clear_i,
   input  logic        latch_en_i,
   input  logic        err_en_i,
   input  logic        mul_en_i,
   input  logic        acc_en_i,
   input  logic [31:0] sample_count_i,
   input  logic [15:0] setpoint_i,
   input  logic [7:0]  kp_i,
   input  logic [7:0]  ki_i,
   output logic [7:0]  duty_o,
   output logic        saturated_o
);

   localparam logic signed [CLAMP_W-1:0] INT_HI     = CLAMP_W'(INT_LIMIT);
   localparam logic signed [CLAMP_W-1:0] INT_LO     = -INT_HI;
   localparam logic signed [CLAMP_W-1:0] DUTY_HI    = CLAMP_W'(DUTY_MAX);
   localparam logic [7:0]                DUTY_MAX_8 = 8'(DUTY_MAX);

   logic        [15:0]          sample_q, sample_d;
   logic signed [ERR_W-1:0]     err_q, err_d;
   logic signed [PROD_W-1:0]    p_q, p_d;
   logic signed [PROD_W-1:0]    inc_q, inc_d;
   logic signed [INT_WIDTH-1:0] integ_q, integ_d;
   logic        [7:0]           duty_q, duty_d;
   logic                        sat_q, sat_d;

   logic signed [PROD_W-1:0]    err_ext;
   logic signed [CLAMP_W-1:0]   integ_sum;
   logic signed [CLAMP_W-1:0]   duty_wide;
   logic signed [SUM_W-1:0]     pi_sum;
   logic signed [SUM_W-1:0]     pi_shifted;
   logic                        err_pos, err_neg, hold;

   // Next values for every pipeline stage, computed from the current registers.
   always_comb begin
      // NOTE: integ_d gets its hold value first so the conditional update below
      // cannot leave it unassigned on any path (which would infer a latch).
      integ_d    = integ_q;

      sample_d   = (|sample_count_i[31:16]) ? 16'hFFFF : sample_count_i[15:0];
      err_d      = $signed({1'b0, setpoint_i}) - $signed({1'b0, sample_q});

      err_ext    = PROD_W'(err_q);
      p_d        = PROD_W'($signed({1'b0, kp_i})) * err_ext;
      inc_d      = PROD_W'($signed({1'b0, ki_i})) * err_ext;

      // Anti-windup: freeze the integrator while it would push further into
      // the rail the duty is already pinned against.
      err_neg    = err_q[ERR_W-1];
      err_pos    = !err_q[ERR_W-1] && (err_q != '0);
      hold       = sat_q && ((duty_q == DUTY_MAX_8 && err_pos) ||
                             (duty_q == 8'd0 && err_neg));
      integ_sum  = CLAMP_W'(integ_q) + CLAMP_W'(inc_q);
      if (!hold) begin
         integ_d = INT_WIDTH'(clamp_s(integ_sum, INT_LO, INT_HI));
      end

      // Duty is formed from the freshly updated integrator in the same stage.
      pi_sum     = SUM_W'(p_q) + SUM_W'(integ_d);
      pi_shifted = pi_sum >>> FRAC_BITS;
      duty_wide  = clamp_s(CLAMP_W'(pi_shifted), '0, DUTY_HI);
      duty_d     = 8'(duty_wide);
      sat_d      = (duty_wide != CLAMP_W'(pi_shifted));
   end

   // Stage registers; leaving the loop (clear_i) discards everything in flight.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every stage samples the values that
      // existed before this edge, independent of statement order.
      if (system_reset || clear_i) begin
         sample_q <= '0;
         err_q    <= '0;
         p_q      <= '0;
         inc_q    <= '0;
         integ_q  <= '0;
         duty_q   <= '0;
         sat_q    <= 1'b0;
      end else begin
         if (latch_en_i) begin
            sample_q <= sample_d;
         end
         if (err_en_i) begin
            err_q <= err_d;
         end
         if (mul_en_i) begin
            p_q   <= p_d;
            inc_q <= inc_d;
         end
         if (acc_en_i) begin
            integ_q <= integ_d;
            duty_q  <= duty_d;
            sat_q   <= sat_d;
         end
      end
   end

   assign duty_o      = duty_q;
   assign saturated_o = sat_q;

endmodule

// File: rtl/speed_pi_controller.sv
// Closed-loop speed controller: sequences one PI update per tachometer sample
// and publishes the resulting PWM duty with a one-cycle valid strobe.
module speed_pi_controller
   import speed_ctrl_pkg::*;
#(
   parameter int FRAC_BITS = 4,
   parameter int INT_WIDTH = 24,
   parameter int INT_LIMIT = 1048575,
   parameter int DUTY_MAX  = 255
) (
   input  logic                 clock,
   input  logic                 system_reset,
   speed_pi_controller_if.slave bus
);

   state_t state_q, state_d;
   logic   latch_en, err_en, mul_en, acc_en;
   logic   busy;
   logic   duty_valid_q, duty_valid_d;
   logic   overrun_q, overrun_d;
   logic   [7:0] duty;
   logic   saturated;

   // State and strobe registers.
   always_ff @(posedge clock) begin
      if (system_reset) begin
         state_q      <= IDLE;
         duty_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         duty_valid_q <= duty_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   // Next state and datapath stage enables; dropping enable overrides all.
   always_comb begin
      state_d  = state_q;
      latch_en = 1'b0;
      err_en   = 1'b0;
      mul_en   = 1'b0;
      acc_en   = 1'b0;

      case (state_q)
         IDLE: if (bus.enable) state_d = WAIT;
         WAIT: begin
            if (bus.sample_valid) begin
               latch_en = 1'b1;
               state_d  = ERR;
            end
         end
         ERR: begin
            err_en  = 1'b1;
            state_d = MUL;
         end
         MUL: begin
            mul_en  = 1'b1;
            state_d = ACC;
         end
         ACC: begin
            acc_en  = 1'b1;
            state_d = OUT;
         end
         OUT:     state_d = WAIT;
         default: state_d = IDLE;
      endcase

      if (!bus.enable) begin
         state_d  = IDLE;
         latch_en = 1'b0;
         err_en   = 1'b0;
         mul_en   = 1'b0;
         acc_en   = 1'b0;
      end

      busy         = (state_q == ERR) || (state_q == MUL) ||
                     (state_q == ACC) || (state_q == OUT);
      // The duty register loads in ACC, so the strobe lands with it in OUT.
      duty_valid_d = acc_en;
      overrun_d    = bus.sample_valid && busy;
   end

   pi_datapath #(
      .FRAC_BITS (FRAC_BITS),
      .INT_WIDTH (INT_WIDTH),
      .INT_LIMIT (INT_LIMIT),
      .DUTY_MAX  (DUTY_MAX)
   ) u_datapath (
      .clock          (clock),
      .system_reset   (system_reset),
      .clear_i        (!bus.enable),
      .latch_en_i     (latch_en),
      .err_en_i       (err_en),
      .mul_en_i       (mul_en),
      .acc_en_i       (acc_en),
      .sample_count_i (bus.sample_count),
      .setpoint_i     (bus.setpoint),
      .kp_i           (bus.kp),
      .ki_i           (bus.ki),
      .duty_o         (duty),
      .saturated_o    (saturated)
   );

   assign bus.duty       = duty;
   assign bus.saturated  = saturated;
   assign bus.duty_valid = duty_valid_q;
   assign bus.overrun    = overrun_q;
   assign bus.busy       = busy;

endmodule

// File: tb/tb_speed_pi_controller.sv
// Self-checking bench for speed_pi_controller: a table of directed updates,
// hand-written multi-cycle corner sequences and a randomized run against a
// plain-arithmetic model of the PI law.
module tb_speed_pi_controller;

   localparam int FRAC_BITS = 4;
   localparam int INT_WIDTH = 24;
   localparam int INT_LIMIT = 1048575;
   localparam int DUTY_MAX  = 255;

   logic clock        = 1'b0;
   logic system_reset = 1'b1;

   always #5 clock = ~clock;

   speed_pi_controller_if bus ();

   speed_pi_controller #(
      .FRAC_BITS (FRAC_BITS),
      .INT_WIDTH (INT_WIDTH),
      .INT_LIMIT (INT_LIMIT),
      .DUTY_MAX  (DUTY_MAX)
   ) dut (
      .clock        (clock),
      .system_reset (system_reset),
      .bus          (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   longint m_integ;
   int     m_duty;
   bit     m_sat;

   typedef struct {
      string       name;
      bit          rst;
      logic [31:0] cnt;
      logic [15:0] sp;
      logic [7:0]  kp;
      logic [7:0]  ki;
      int          exp_duty;
      bit          exp_sat;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic model_reset();
      m_integ = 0;
      m_duty  = 0;
      m_sat   = 1'b0;
   endtask

   // One PI update computed directly from the control law with integer math.
   task automatic model_update(input longint cnt, input longint sp, input longint kp, input longint ki);
      longint s, err, p, inc, total, q, scale;
      bit     hold;
      scale = longint'(1) << FRAC_BITS;
      s     = (cnt > 65535) ? 65535 : cnt;
      err   = sp - s;
      p     = kp * err;
      inc   = ki * err;
      hold  = m_sat && ((m_duty == DUTY_MAX && err > 0) || (m_duty == 0 && err < 0));
      if (!hold) begin
         m_integ = m_integ + inc;
         if (m_integ > INT_LIMIT)  m_integ = INT_LIMIT;
         if (m_integ < -INT_LIMIT) m_integ = -INT_LIMIT;
      end
      total = p + m_integ;
      q = (total >= 0) ? total / scale : -((-total + scale - 1) / scale);
      if (q < 0) begin
         m_duty = 0;
         m_sat  = 1'b1;
      end else if (q > DUTY_MAX) begin
         m_duty = DUTY_MAX;
         m_sat  = 1'b1;
      end else begin
         m_duty = int'(q);
         m_sat  = 1'b0;
      end
   endtask

   task automatic set_gains(input logic [15:0] sp, input logic [7:0] kp, input logic [7:0] ki);
      bus.setpoint = sp;
      bus.kp       = kp;
      bus.ki       = ki;
   endtask

   task automatic do_reset();
      @(negedge clock);
      system_reset     = 1'b1;
      bus.enable       = 1'b0;
      bus.sample_valid = 1'b0;
      repeat (2) @(negedge clock);
      check("reset duty", bus.duty, 0);
      check("reset duty_valid", bus.duty_valid, 0);
      check("reset busy", bus.busy, 0);
      check("reset saturated", bus.saturated, 0);
      check("reset overrun", bus.overrun, 0);
      system_reset = 1'b0;
      bus.enable   = 1'b1;
      model_reset();
   endtask

   // Strobe one sample and check the update lands exactly four cycles later.
   task automatic run_update(input string name, input logic [31:0] cnt, input int exp_duty, input bit exp_sat);
      int early;
      early = 0;
      @(negedge clock);
      bus.sample_valid = 1'b1;
      bus.sample_count = cnt;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock);
         if (k == 1) bus.sample_valid = 1'b0;
         if (k < 4 && bus.duty_valid === 1'b1) early++;
      end
      check({name, " duty_valid"}, bus.duty_valid, 1);
      check({name, " duty"}, bus.duty, exp_duty);
      check({name, " saturated"}, bus.saturated, exp_sat);
      check({name, " early_valid"}, early, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          ov_cnt, dv_cnt, busy_cnt, duty_at4, dv_at4;
      int          mode;
      logic [31:0] r_cnt;
      logic [15:0] r_sp;
      logic [7:0]  r_kp, r_ki;

      bus.enable       = 1'b0;
      bus.sample_valid = 1'b0;
      bus.sample_count = '0;
      bus.setpoint     = '0;
      bus.kp           = '0;
      bus.ki           = '0;

      //           name           rst   cnt            sp         kp      ki      duty sat
      vecs[0]  = '{"p_only",      1'b1, 32'd60,        16'd100,   8'd8,   8'd0,   20,  1'b0};
      vecs[1]  = '{"pi_first",    1'b1, 32'd60,        16'd100,   8'd8,   8'd2,   25,  1'b0};
      vecs[2]  = '{"pi_second",   1'b0, 32'd60,        16'd100,   8'd8,   8'd2,   30,  1'b0};
      vecs[3]  = '{"sat_high",    1'b1, 32'd0,         16'd1000,  8'd255, 8'd4,   255, 1'b1};
      vecs[4]  = '{"hold_high",   1'b0, 32'd0,         16'd1000,  8'd255, 8'd4,   255, 1'b1};
      vecs[5]  = '{"sat_low",     1'b0, 32'd2000,      16'd1000,  8'd255, 8'd4,   0,   1'b1};
      vecs[6]  = '{"unwind_hi",   1'b0, 32'd990,       16'd1000,  8'd0,   8'd4,   2,   1'b0};
      vecs[7]  = '{"drive_low",   1'b0, 32'd2000,      16'd1000,  8'd255, 8'd4,   0,   1'b1};
      vecs[8]  = '{"hold_low",    1'b0, 32'd2000,      16'd1000,  8'd255, 8'd4,   0,   1'b1};
      vecs[9]  = '{"unwind_lo",   1'b0, 32'd0,         16'd1000,  8'd0,   8'd4,   2,   1'b0};
      vecs[10] = '{"clamp_65536", 1'b1, 32'h0001_0000, 16'd65535, 8'd1,   8'd0,   0,   1'b0};
      vecs[11] = '{"clamp_max",   1'b1, 32'hFFFF_FFFF, 16'd65535, 8'd1,   8'd1,   0,   1'b0};
      vecs[12] = '{"err_one",     1'b1, 32'd65534,     16'd65535, 8'd16,  8'd0,   1,   1'b0};
      vecs[13] = '{"err_neg_max", 1'b1, 32'd65535,     16'd0,     8'd255, 8'd0,   0,   1'b1};
      vecs[14] = '{"int_clamp",   1'b1, 32'd0,         16'd65535, 8'd0,   8'd255, 255, 1'b1};
      vecs[15] = '{"int_unwind",  1'b0, 32'd65535,     16'd0,     8'd0,   8'd16,  0,   1'b0};

      for (int i = 0; i < 16; i++) begin
         if (vecs[i].rst) do_reset();
         set_gains(vecs[i].sp, vecs[i].kp, vecs[i].ki);
         run_update(vecs[i].name, vecs[i].cnt, vecs[i].exp_duty, vecs[i].exp_sat);
      end

      // Overrun: a second strobe during MUL is dropped, one update only.
      do_reset();
      set_gains(16'd65535, 8'd1, 8'd0);
      ov_cnt   = 0;
      dv_cnt   = 0;
      busy_cnt = 0;
      duty_at4 = -1;
      dv_at4   = 0;
      @(negedge clock);
      bus.sample_valid = 1'b1;
      bus.sample_count = 32'd65519;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         if (bus.overrun === 1'b1)    ov_cnt++;
         if (bus.duty_valid === 1'b1) dv_cnt++;
         if (bus.busy === 1'b1)       busy_cnt++;
         if (k == 4) begin
            duty_at4 = int'(bus.duty);
            dv_at4   = int'(bus.duty_valid);
         end
         if (k == 1) bus.sample_valid = 1'b0;
         if (k == 2) begin
            bus.sample_valid = 1'b1;
            bus.sample_count = 32'd0;
         end
         if (k == 3) bus.sample_valid = 1'b0;
      end
      check("overrun pulses", ov_cnt, 1);
      check("overrun duty_valid pulses", dv_cnt, 1);
      check("overrun busy cycles", busy_cnt, 4);
      check("overrun duty_valid at N+4", dv_at4, 1);
      check("overrun duty", duty_at4, 1);

      // Enable dropped in ACC: result discarded, loop state cleared.
      do_reset();
      set_gains(16'd100, 8'd8, 8'd2);
      run_update("en_pre", 32'd60, 25, 1'b0);
      @(negedge clock);
      bus.sample_valid = 1'b1;
      bus.sample_count = 32'd60;
      @(negedge clock);
      bus.sample_valid = 1'b0;
      repeat (2) @(negedge clock);
      bus.enable = 1'b0;
      @(negedge clock);
      check("en_drop duty_valid", bus.duty_valid, 0);
      check("en_drop duty", bus.duty, 0);
      check("en_drop saturated", bus.saturated, 0);
      check("en_drop busy", bus.busy, 0);
      dv_cnt = 0;
      repeat (3) begin
         @(negedge clock);
         if (bus.duty_valid === 1'b1) dv_cnt++;
      end
      check("en_drop late duty_valid", dv_cnt, 0);
      bus.enable = 1'b1;
      run_update("en_fresh", 32'd60, 25, 1'b0);

      // Reset asserted while in MUL.
      do_reset();
      set_gains(16'd1000, 8'd255, 8'd0);
      run_update("rst_pre", 32'd0, 255, 1'b1);
      @(negedge clock);
      bus.sample_valid = 1'b1;
      bus.sample_count = 32'd0;
      @(negedge clock);
      bus.sample_valid = 1'b0;
      @(negedge clock);
      system_reset = 1'b1;
      @(negedge clock);
      check("rst_mid duty", bus.duty, 0);
      check("rst_mid duty_valid", bus.duty_valid, 0);
      check("rst_mid saturated", bus.saturated, 0);
      check("rst_mid busy", bus.busy, 0);
      check("rst_mid overrun", bus.overrun, 0);
      system_reset = 1'b0;
      dv_cnt = 0;
      repeat (5) begin
         @(negedge clock);
         if (bus.duty_valid === 1'b1) dv_cnt++;
      end
      check("rst_mid late duty_valid", dv_cnt, 0);

      // Randomized updates against the reference model.
      for (int i = 0; i < 60; i++) begin
         if (i % 12 == 0) do_reset();
         mode = ($urandom_range(0, 7) == 0) ? 0 : 1;
         if (mode == 0) begin
            r_sp  = 16'($urandom);
            r_cnt = $urandom;
            r_kp  = 8'($urandom);
            r_ki  = 8'($urandom);
         end else begin
            r_sp  = 16'($urandom_range(200, 3000));
            r_cnt = 32'(r_sp) + 32'($urandom_range(0, 400)) - 32'd200;
            r_kp  = 8'($urandom_range(0, 40));
            r_ki  = 8'($urandom_range(0, 6));
         end
         set_gains(r_sp, r_kp, r_ki);
         model_update(longint'(r_cnt), longint'(r_sp), longint'(r_kp), longint'(r_ki));
         run_update($sformatf("rand%0d", i), r_cnt, m_duty, m_sat);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
